// File: rtl/mvm_pkg.sv
// mvm_pkg: shared encodings, FSM states and fixed-point helpers for the mvm tile engine
package mvm_pkg;
    typedef enum logic [1:0] {OP_MEM, OP_BUF, OP_STORE, OP_NOP} op_e;
    typedef enum logic [1:0] {ACT_NONE, ACT_RELU, ACT_HTANH, ACT_NONE3} act_e;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_DRAIN, S_STORE, S_FIN} state_e;
    localparam int SW = 48;
    typedef logic signed [SW-1:0] wide_t;

    function automatic wide_t sat(input wide_t v, input int w, input logic sym);
        wide_t hi, lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = sym ? -hi : -hi - wide_t'(1);
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

    function automatic wide_t act(input wide_t v, input act_e a, input int frac);
        wide_t lim;
        lim = wide_t'(1) <<< frac;
        return a == ACT_RELU ? (v < 0 ? '0 : v) :
               a == ACT_HTANH ? (v > lim ? lim : (v < -lim ? -lim : v)) : v;
    endfunction
endpackage

// File: rtl/mvm_tile_engine_lane.sv
// mvm_lane: one output lane, bias preload then sticky symmetric-saturating multiply-accumulate
module mvm_lane
    import mvm_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int W_W   = 8,
    parameter int B_W   = 15,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ld,
    input  logic                    en,
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [W_W-1:0]   w,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [IN_W+W_W-1:0] prod;
    wide_t sum, nxt;
    logic stuck;

    assign prod = x * w;
    assign sum  = wide_t'(acc) + wide_t'(prod);
    assign nxt  = sat(sum, ACC_W, 1'b1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc   <= '0;
            stuck <= 1'b0;
        end else if (ld) begin
            acc   <= ACC_W'(b);
            stuck <= 1'b0;
        end else if (en && !stuck) begin
            acc   <= ACC_W'(nxt);
            stuck <= nxt != sum;
        end
endmodule

// File: rtl/mvm_tile_engine.sv
// mvm_tile_engine: tiled y = act(W*x + b) over DOP lanes with ping-pong vector buffer and STORE
module mvm_tile_engine
    import mvm_pkg::*;
#(
    parameter int DOP     = 32,
    parameter int IN_W    = 16,
    parameter int W_W     = 8,
    parameter int B_W     = 15,
    parameter int ACC_W   = 24,
    parameter int FRAC_SH = 7,
    parameter int MAX_DIM = 256,
    parameter int AW      = 16,
    parameter int DIM_W   = $clog2(MAX_DIM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [1:0]           cmd_act,
    input  logic [DIM_W-1:0]     cmd_dimi,
    input  logic [DIM_W-1:0]     cmd_dimo,
    input  logic [AW-1:0]        cmd_bias_base,
    input  logic [AW-1:0]        cmd_w_base,
    input  logic [AW-1:0]        cmd_dio_base,
    output logic                 din_rd,
    output logic [AW-1:0]        din_addr,
    input  logic [IN_W-1:0]      din_dat,
    output logic                 w_rd,
    output logic [AW-1:0]        w_addr,
    input  logic [DOP*W_W-1:0]   w_dat,
    output logic                 b_rd,
    output logic [AW-1:0]        b_addr,
    input  logic [DOP*B_W-1:0]   b_dat,
    output logic                 dout_we,
    output logic [AW-1:0]        dout_addr,
    output logic [IN_W-1:0]      dout_dat,
    output logic                 busy,
    output logic                 done
);
    localparam int CW = DIM_W + 1;
    localparam int LW = $clog2(DOP);

    state_e state;
    op_e act_op_unused_guard;
    op_e op_r;
    act_e act_r;
    logic [CW-1:0] dimi, dimo, rem, cnt;
    logic [LW-1:0] lane;
    logic [AW-1:0] dio_base, tile_w;
    logic bank;
    logic [IN_W-1:0] vbuf [2*MAX_DIM];
    logic [IN_W-1:0] rd_dat, drain_dat;
    logic [DIM_W-1:0] rd_idx, wr_idx;
    logic signed [ACC_W-1:0] acc [DOP];
    logic signed [IN_W-1:0] x_in;
    logic lane_ld, lane_en, lane_last;
    wide_t drain_v;

    assign act_op_unused_guard = op_r;
    assign cmd_ready = state == S_IDLE;
    assign busy      = !cmd_ready;
    assign done      = state == S_FIN;
    assign dout_dat  = dout_we ? rd_dat : '0;
    assign x_in      = act_op_unused_guard == OP_BUF ? rd_dat : din_dat;
    assign lane_ld   = state == S_MAC && cnt == '0;
    assign lane_en   = state == S_MAC && cnt != '0;
    assign lane_last = rem > CW'(DOP) ? lane == LW'(DOP - 1) : CW'(lane) == rem - CW'(1);
    assign wr_idx    = DIM_W'(dimo - rem + CW'(lane));
    assign rd_idx    = state == S_STORE ? DIM_W'(cnt + CW'(1)) : state == S_MAC ? DIM_W'(cnt) : '0;
    assign drain_v   = wide_t'(acc[lane]) >>> FRAC_SH;
    assign drain_dat = IN_W'(sat(act(drain_v, act_r, FRAC_SH), IN_W, 1'b0));

    for (genvar i = 0; i < DOP; i++) begin : g_lane
        mvm_lane #(.IN_W(IN_W), .W_W(W_W), .B_W(B_W), .ACC_W(ACC_W)) u_lane (
            .clk(clk), .rst_n(rst_n), .ld(lane_ld), .en(lane_en), .x(x_in),
            .w(w_dat[i*W_W +: W_W]), .b(b_dat[i*B_W +: B_W]), .acc(acc[i])
        );
    end

    // One read port serves both MAC operand fetch (src bank) and STORE readout
    always_ff @(posedge clk) begin
        if (state == S_DRAIN) vbuf[{~bank, wr_idx}] <= drain_dat;
        rd_dat <= vbuf[{bank, rd_idx}];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_r <= OP_MEM;
            act_r <= ACT_NONE;
            {dimi, dimo, rem, cnt} <= '0;
            lane <= '0;
            {dio_base, tile_w} <= '0;
            bank <= 1'b0;
            {din_rd, w_rd, b_rd, dout_we} <= '0;
            {din_addr, w_addr, b_addr, dout_addr} <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    op_r <= op_e'(cmd_op);
                    act_r <= act_e'(cmd_act);
                    dimi <= CW'(cmd_dimi) + CW'(1);
                    dimo <= CW'(cmd_dimo) + CW'(1);
                    rem <= CW'(cmd_dimo) + CW'(1);
                    cnt <= '0;
                    dio_base <= cmd_dio_base;
                    tile_w <= cmd_w_base;
                    b_addr <= cmd_bias_base;
                    b_rd <= !cmd_op[1];
                    dout_we <= cmd_op == 2'd2;
                    dout_addr <= cmd_dio_base;
                    state <= cmd_op[1] ? (cmd_op[0] ? S_FIN : S_STORE) : S_FETCH;
                end
                S_FETCH: begin
                    b_rd <= 1'b0;
                    w_rd <= 1'b1;
                    w_addr <= tile_w;
                    din_rd <= op_r == OP_MEM;
                    din_addr <= dio_base;
                    cnt <= '0;
                    state <= S_MAC;
                end
                S_MAC: if (cnt == dimi) begin
                    state <= S_DRAIN;
                    lane <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                    w_rd <= w_rd && (cnt + CW'(1) != dimi);
                    din_rd <= din_rd && (cnt + CW'(1) != dimi);
                    w_addr <= w_addr + AW'(1);
                    din_addr <= din_addr + AW'(2);
                end
                S_DRAIN: if (!lane_last) lane <= lane + LW'(1);
                else if (rem > CW'(DOP)) begin
                    rem <= rem - CW'(DOP);
                    tile_w <= tile_w + AW'(dimi);
                    b_addr <= b_addr + AW'(1);
                    b_rd <= 1'b1;
                    state <= S_FETCH;
                end else begin
                    bank <= ~bank;
                    state <= S_FIN;
                end
                S_STORE: if (cnt == dimo - CW'(1)) begin
                    dout_we <= 1'b0;
                    state <= S_FIN;
                end else begin
                    cnt <= cnt + CW'(1);
                    dout_addr <= dout_addr + AW'(2);
                end
                S_FIN: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mvm_tile_engine.sv
// tb_mvm_tile_engine: directed vectors with hand-computed results for mvm_tile_engine
module tb_mvm_tile_engine;
    localparam int DOP = 32, IN_W = 16, W_W = 8, B_W = 15, AW = 16, DIM_W = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_op = '0, cmd_act = '0;
    logic [DIM_W-1:0] cmd_dimi = '0, cmd_dimo = '0;
    logic [AW-1:0] cmd_bias_base = '0, cmd_w_base = '0, cmd_dio_base = '0;
    logic din_rd, w_rd, b_rd, dout_we, busy, done;
    logic [AW-1:0] din_addr, w_addr, b_addr, dout_addr;
    logic [IN_W-1:0] din_dat = '0, dout_dat;
    logic [DOP*W_W-1:0] w_dat = '0;
    logic [DOP*B_W-1:0] b_dat = '0;

    logic [DOP*W_W-1:0] wmem [1024];
    logic [DOP*B_W-1:0] bmem [64];
    logic [IN_W-1:0] dmem [4096];
    int total = 0, bad = 0, done_cnt = 0, rd_cnt = 0;
    int wlog[$], blog[$], sa[$], sd[$];

    mvm_tile_engine dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_act(cmd_act), .cmd_dimi(cmd_dimi), .cmd_dimo(cmd_dimo),
        .cmd_bias_base(cmd_bias_base), .cmd_w_base(cmd_w_base), .cmd_dio_base(cmd_dio_base),
        .din_rd(din_rd), .din_addr(din_addr), .din_dat(din_dat),
        .w_rd(w_rd), .w_addr(w_addr), .w_dat(w_dat),
        .b_rd(b_rd), .b_addr(b_addr), .b_dat(b_dat),
        .dout_we(dout_we), .dout_addr(dout_addr), .dout_dat(dout_dat),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (din_rd) din_dat <= dmem[din_addr[11:0]];
        if (w_rd) w_dat <= wmem[w_addr[9:0]];
        if (b_rd) b_dat <= bmem[b_addr[5:0]];
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (din_rd) rd_cnt++;
        if (w_rd) wlog.push_back(int'(w_addr));
        if (b_rd) blog.push_back(int'(b_addr));
        if (dout_we) begin
            sa.push_back(int'(dout_addr));
            sd.push_back(int'($signed(dout_dat)));
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_w(input int row, input int ln, input int val);
        wmem[row][ln*W_W +: W_W] = W_W'(val);
    endtask

    task automatic set_b(input int row, input int ln, input int val);
        bmem[row][ln*B_W +: B_W] = B_W'(val);
    endtask

    task automatic issue(input int op, input int ac, input int di, input int dout,
                         input int bb, input int wb, input int db);
        @(negedge clk);
        cmd_op = 2'(op); cmd_act = 2'(ac);
        cmd_dimi = DIM_W'(di); cmd_dimo = DIM_W'(dout);
        cmd_bias_base = AW'(bb); cmd_w_base = AW'(wb); cmd_dio_base = AW'(db);
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input bit poke);
        int lat = 1;
        int d0 = done_cnt;
        while (!done && lat < 3000) begin
            if (poke && lat == 2) cmd_valid = 1'b1;
            if (poke && lat == 4) cmd_valid = 1'b0;
            @(posedge clk);
            #1 lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " ready in FIN"}, cmd_ready, 0);
        @(posedge clk);
        #1;
        check({tag, " ready after"}, cmd_ready, 1);
        check({tag, " done pulses"}, done_cnt - d0, 1);
    endtask

    task automatic check_store(input string tag, input int s0, input int base, input int e[$]);
        check({tag, " writes"}, sa.size() - s0, e.size());
        foreach (e[i])
            if (s0 + i < sa.size()) begin
                check($sformatf("%s addr[%0d]", tag, i), sa[s0+i], base + 2 * i);
                check($sformatf("%s data[%0d]", tag, i), sd[s0+i], e[i]);
            end
    endtask

    initial begin
        int s0, r0, w0, b0;
        int e[$];
        for (int i = 0; i < 1024; i++) wmem[i] = '0;
        for (int i = 0; i < 64; i++) bmem[i] = '0;
        for (int i = 0; i < 4096; i++) dmem[i] = '0;
        // layer A: x=[128,256,-128]
        dmem['h100] = 16'd128; dmem['h102] = 16'd256; dmem['h104] = 16'hff80;
        set_w(0, 0, 1); set_w(1, 0, 1); set_w(2, 0, 1);
        set_w(0, 1, 2); set_w(2, 2, -1); set_b(0, 1, 128);
        // two-tile layer
        dmem['h300] = 16'd128; dmem['h302] = 16'd128;
        for (int i = 0; i < 32; i++) begin
            set_w(16, i, i); set_w(17, i, 1); set_w(18, i, -i); set_w(19, i, 2); set_b(9, i, 256);
        end
        // saturation layer
        for (int k = 0; k < 256; k++) begin
            dmem['h500 + 2*k] = 16'd32767;
            set_w(64 + k, 0, 127); set_w(64 + k, 1, -127);
        end
        // chained layers
        dmem['h600] = 16'd128; dmem['h602] = 16'd256;
        for (int i = 0; i < 4; i++) begin
            set_w(400, i, i + 1); set_w(401, i, 1);
        end
        for (int k = 0; k < 4; k++) begin
            set_w(500 + k, 0, 32); set_w(500 + k, 1, -32); set_w(500 + k, 3, 100);
        end
        set_w(503, 2, 64); set_b(20, 3, -1000);

        repeat (2) @(posedge clk);
        #1;
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst strobes", {din_rd, w_rd, b_rd, dout_we}, 0);
        check("rst addrs", {din_addr, w_addr, b_addr, dout_addr}, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle no done", done_cnt, 0);
        check("idle ready", cmd_ready, 1);

        s0 = sa.size(); r0 = rd_cnt;
        issue(0, 0, 2, 2, 0, 0, 'h100);
        wait_done("mvm_a", 9, 1);
        check("mvm_a din reads", rd_cnt - r0, 3);
        check("mvm_a no writes", sa.size() - s0, 0);
        issue(2, 0, 0, 2, 0, 0, 'h200);
        wait_done("store_a", 4, 0);
        e = {2, 3, 1};
        check_store("store_a", s0, 'h200, e);

        s0 = sa.size(); w0 = wlog.size(); b0 = blog.size();
        issue(0, 0, 1, 39, 8, 16, 'h300);
        wait_done("mvm_b", 49, 0);
        check("mvm_b b reads", blog.size() - b0, 2);
        if (blog.size() - b0 == 2) begin
            check("mvm_b b_addr0", blog[b0], 8);
            check("mvm_b b_addr1", blog[b0+1], 9);
        end
        check("mvm_b w reads", wlog.size() - w0, 4);
        for (int i = 0; i < 4; i++)
            if (w0 + i < wlog.size()) check($sformatf("mvm_b w_addr%0d", i), wlog[w0+i], 16 + i);
        issue(2, 0, 0, 39, 0, 0, 'h400);
        wait_done("store_b", 41, 0);
        e.delete();
        for (int i = 0; i < 40; i++) e.push_back(i < 32 ? i + 1 : 36 - i);
        check_store("store_b", s0, 'h400, e);

        for (int a = 0; a < 3; a++) begin
            s0 = sa.size();
            issue(0, a, 255, 1, 30, 64, 'h500);
            wait_done($sformatf("sat act%0d", a), 261, 0);
            issue(2, 0, 0, 1, 0, 0, 'h800);
            wait_done("store_sat", 3, 0);
            e = a == 0 ? {32767, -32768} : a == 1 ? {32767, 0} : {128, -128};
            check_store($sformatf("sat act%0d", a), s0, 'h800, e);
        end

        issue(3, 0, 0, 0, 0, 0, 0);
        wait_done("nop", 1, 0);

        s0 = sa.size();
        issue(0, 1, 1, 3, 21, 400, 'h600);
        wait_done("chain l1", 9, 0);
        r0 = rd_cnt;
        issue(1, 3, 3, 3, 20, 500, 0);
        wait_done("chain l2", 11, 0);
        check("chain l2 din reads", rd_cnt - r0, 0);
        issue(2, 0, 0, 3, 0, 0, 'h700);
        wait_done("chain store", 5, 0);
        e = {4, -5, 3, 6};
        check_store("chain", s0, 'h700, e);

        issue(0, 0, 2, 2, 0, 0, 'h100);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort cmd_ready", cmd_ready, 1);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort strobes", {din_rd, w_rd, b_rd, dout_we}, 0);
        check("abort addrs", {din_addr, w_addr, b_addr, dout_addr}, 0);
        @(negedge clk) rst_n = 1'b1;
        s0 = sa.size();
        issue(0, 0, 2, 2, 0, 0, 'h100);
        wait_done("rerun", 9, 0);
        issue(2, 0, 0, 2, 0, 0, 'h200);
        wait_done("rerun store", 4, 0);
        e = {2, 3, 1};
        check_store("rerun", s0, 'h200, e);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mvm_tile_engine.md
# mvm_tile_engine

Parametrised matrix-vector multiply engine for the autoencoder datapath. It computes y = act(W·x + b) for one layer per command, tiled over DOP output lanes. Input vectors come from external data memory or from an internal ping-pong vector buffer, so layers can be chained without a round trip. A STORE command writes the buffer back to memory. It sits between the instruction sequencer and the weight/bias/data SRAMs.

## Interface
- DOP, 32, parallel output lanes (MAC units)
- IN_W, 16, activation/data width (signed)
- W_W, 8, weight width (signed)
- B_W, 15, bias width (signed)
- ACC_W, 24, accumulator width (signed, saturating)
- FRAC_SH, 7, arithmetic right shift applied to acc before activation
- MAX_DIM, 256, max vector length; DIM_W = $clog2(MAX_DIM)
- AW, 16, data/weight/bias address width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=MVM_MEM, 1=MVM_BUF, 2=STORE, 3=reserved (accepted, treated as NOP)
- cmd_act  in  2  0=none, 1=ReLU, 2=hard-tanh clamp to ±(1<<FRAC_SH), 3=none
- cmd_dimi, cmd_dimo  in  DIM_W  vector length minus 1
- cmd_bias_base, cmd_w_base, cmd_dio_base  in  AW  base addresses
- din_rd / din_addr / din_dat  out 1 / out AW / in IN_W  data memory read, 1-cycle latency
- w_rd / w_addr / w_dat  out 1 / out AW / in DOP*W_W  weight row read (lane i at bits [i*W_W+:W_W])
- b_rd / b_addr / b_dat  out 1 / out AW / in DOP*B_W  bias row read
- dout_we / dout_addr / dout_dat  out 1 / out AW / out IN_W  data memory write
- busy  out  1  ~cmd_ready
- done  out  1  one-cycle pulse on command completion

## Operation
- Accept when cmd_valid&cmd_ready; latch all fields; dims stored as field+1.
- Vector buffer: two banks of MAX_DIM×IN_W; src_bank read, dst_bank written; banks swap at end of each MVM command.
- FSM: IDLE → FETCH (issue b_rd at bias_base+tile) → MAC → DRAIN → (next tile ? FETCH : FIN) → IDLE. STORE: IDLE → STORE → FIN → IDLE. NOP: IDLE → FIN → IDLE.
- Tiles: ntiles = ceil(dimo/DOP); last tile has dimo-DOP*(ntiles-1) live lanes; inactive lanes are computed but not drained.
- MAC: k=0..dimi-1 issues x read (din_addr=dio_base+2k for MVM_MEM, src_bank[k] for MVM_BUF) and w_addr=w_base+tile*dimi+k. Input is re-read per tile, so no replay FIFO.
- Lane acc preloads sign-extended bias, then acc += x*w; saturates at ±(2^(ACC_W-1)-1) on every step, sticky.
- DRAIN: one lane per cycle: v = acc>>>FRAC_SH, apply act, saturate to IN_W, write dst_bank[tile*DOP+lane].
- STORE: for k=0..dimo-1, dout_we=1, dout_addr=dio_base+2k, dout_dat=src_bank[k] (last-written bank).
- Memory read enables are high only in the cycles in which reads are issued.

## Timing
- Reset: cmd_ready=1, busy=0, done=0, all *_rd=0, dout_we=0, all addresses 0, bank select 0; accumulators cleared.
- FETCH: 1 cycle. MAC: dimi+1 cycles (one cycle for read latency). DRAIN: live-lane-count cycles.
- MVM latency from accept to done = Σtiles(1+dimi+1+lanes)+1. STORE latency = dimo+1.
- cmd_valid while busy: ignored and not queued.
- done asserts in FIN; cmd_ready rises the cycle after.
- Async reset mid-command aborts immediately; buffer contents are undefined afterwards.
- MVM_BUF with dimi greater than the previous layer's dimo reads stale buffer data; no error flag is raised.

## Structure
- Package mvm_pkg: op/act encodings, FSM state enum, sat() and act() functions.
- Sub-module mvm_lane (bias preload, saturating MAC, acc output), instanced DOP times. The vector buffer is inferred RAM inside the top level.

## Test plan
- Reset then idle -> cmd_ready=1, all strobes 0, done never pulses.
- MVM_MEM dimi=3, dimo=3 (fields 2/2), x=[128,256,-128] (Q7), W lane0=[1,1,1], b0=0, act none -> buffer[0]=(128+256-128)>>7=2; latency 1+4+3+1=9 cycles.
- dimo=40 (field 39), DOP=32 -> two tiles, 32+8 drain writes, b_addr 0 then 1, w_addr restarts at w_base+dimi.
- Acc overflow (all x=32767, w=127, dimi=256) -> acc clamps at 2^23-1, out saturates to 32767; ReLU on negative gives 0; hard-tanh gives ±128.
- MVM_MEM then MVM_BUF then STORE dimo=4 -> 4 writes at dio_base, +2, +4, +6 with second-layer results; done pulses once per command.
- Assert rst_n mid-MAC -> all outputs return to reset values asynchronously; a new command after release completes correctly.
